// File: rtl/grid_scan_controller.sv
// Row-major board scanner: reads each cell through a 2-cycle RAM and hands non-empty cells to the tile drawer.
// Per cell: 4 cycles if skipped, 5 + wait cycles if drawn; waits on draw_done up to a bounded count.
module grid_scan_controller #(
  parameter int COLS         = 10,
  parameter int ROWS         = 10,
  parameter int SKIP_EMPTY   = 1,
  parameter int CONTINUOUS   = 0,
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  output logic [7:0] ram_addr,
  input  logic [7:0] ram_q,
  output logic [7:0] address,
  output logic [7:0] position,
  output logic       draw_start,
  input  logic       draw_done,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count,
  output logic       timeout
);

  localparam int WW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [3:0]    LAST_COL = 4'(COLS - 1);
  localparam logic [3:0]    LAST_ROW = 4'(ROWS - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(DONE_TIMEOUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_START = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_NEXT  = 3'd6;
  localparam logic [2:0] S_FDONE = 3'd7;

  logic [2:0]    state;
  logic [3:0]    row;
  logic [3:0]    col;
  logic [WW-1:0] wait_cnt;
  logic [3:0]    next_row;
  logic [3:0]    next_col;
  logic          last_col;
  logic          last_cell;

  always_comb begin
    last_col  = (col == LAST_COL);
    next_col  = last_col ? 4'd0 : col + 4'd1;
    next_row  = last_col ? row + 4'd1 : row;
    last_cell = last_col && (row == LAST_ROW);
  end

  assign busy = (state != S_IDLE);

  // ram_addr is loaded on entry to ADDR so the RAM's 2-cycle latency lands exactly on LATCH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      row         <= '0;
      col         <= '0;
      ram_addr    <= '0;
      address     <= '0;
      position    <= '0;
      frame_count <= '0;
      draw_start  <= 1'b0;
      frame_done  <= 1'b0;
      timeout     <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      draw_start <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go || (CONTINUOUS != 0)) begin
            row      <= '0;
            col      <= '0;
            ram_addr <= '0;
            state    <= S_ADDR;
          end
        end
        S_ADDR:  state <= S_READ;
        S_READ:  state <= S_LATCH;
        S_LATCH: begin
          address  <= {row, col};
          position <= ram_q;
          if ((SKIP_EMPTY != 0) && (ram_q == 8'h00)) begin
            state <= S_NEXT;
          end else begin
            draw_start <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // First WAIT cycle ignores draw_done: it may still be the previous tile's done.
          if ((wait_cnt != '0) && draw_done) begin
            state <= S_NEXT;
          end else if (wait_cnt == WAIT_MAX) begin
            timeout <= 1'b1;
            state   <= S_NEXT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          if (last_cell) begin
            row         <= '0;
            col         <= '0;
            ram_addr    <= '0;
            frame_count <= frame_count + 8'd1;
            frame_done  <= 1'b1;
            state       <= S_FDONE;
          end else begin
            row      <= next_row;
            col      <= next_col;
            ram_addr <= {next_row, next_col};
            state    <= S_ADDR;
          end
        end
        S_FDONE: begin
          if (CONTINUOUS != 0) state <= S_ADDR;
          else                 state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_scan_controller.sv
// Scoreboarded bench: a frame-level model pushes expected draws and frame timing; monitors pop and compare.
module tb_grid_scan_controller;
  localparam int TMO = 100;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, go, draw_done;
  logic [7:0] ram_q, ram_addr, address, position, frame_count;
  logic       draw_start, busy, frame_done, timeout;

  logic       rst_b;
  logic       go_b = 1'b0;
  logic       draw_done_b = 1'b0;
  logic [7:0] ram_q_b, ram_addr_b, address_b, position_b, frame_count_b;
  logic       draw_start_b, busy_b, frame_done_b, timeout_b;

  grid_scan_controller #(.COLS(10), .ROWS(10), .SKIP_EMPTY(1), .CONTINUOUS(0), .DONE_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .go(go), .ram_addr(ram_addr), .ram_q(ram_q),
    .address(address), .position(position), .draw_start(draw_start), .draw_done(draw_done),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count), .timeout(timeout));

  grid_scan_controller #(.COLS(3), .ROWS(2), .SKIP_EMPTY(1), .CONTINUOUS(1), .DONE_TIMEOUT(15)) dut_b (
    .clock(clock), .reset(rst_b), .go(go_b), .ram_addr(ram_addr_b), .ram_q(ram_q_b),
    .address(address_b), .position(position_b), .draw_start(draw_start_b), .draw_done(draw_done_b),
    .busy(busy_b), .frame_done(frame_done_b), .frame_count(frame_count_b), .timeout(timeout_b));

  // Board RAMs with two cycles of read latency.
  logic [7:0] mem [256];
  logic [7:0] q1, qb1;
  always @(posedge clock) begin
    q1      <= mem[ram_addr];
    ram_q   <= q1;
    qb1     <= (ram_addr_b == 8'h12) ? 8'h55 : 8'h00;
    ram_q_b <= qb1;
  end

  typedef struct {
    bit         is_frame;
    logic [7:0] addr;
    logic [7:0] pos;
    int         dur;
    logic [7:0] cnt;
  } exp_t;

  exp_t expq[$];
  int   delayq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   drv_mode = 2;
  int   dcnt = 0;
  int   exp_frames = 0;
  int   b_frames = 0;
  bit   b_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Frame model: a skipped cell costs 4 cycles, a drawn cell 5 + W, W = drawer delay (or 2 when done is stuck high).
  task automatic model_frame(input int mode, input int fixed_d);
    int   dur;
    int   w;
    exp_t e;
    dur = 0;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        logic [7:0] a;
        a = 8'(r * 16 + c);
        if (mem[a] == 8'h00) begin
          dur += 4;
        end else begin
          if (mode == 0) begin
            w = (fixed_d > 0) ? fixed_d : int'($urandom_range(2, 12));
            delayq.push_back(w);
          end else begin
            w = 2;
          end
          dur += 5 + w;
          e.is_frame = 1'b0; e.addr = a; e.pos = mem[a]; e.dur = 0; e.cnt = 8'h00;
          expq.push_back(e);
        end
      end
    end
    exp_frames = (exp_frames + 1) % 256;
    e.is_frame = 1'b1; e.addr = 8'h00; e.pos = 8'h00;
    e.dur = (mode == 2) ? -1 : dur;
    e.cnt = 8'(exp_frames);
    expq.push_back(e);
  endtask

  task automatic clear_board();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
  endtask

  task automatic random_board();
    clear_board();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        if ($urandom_range(0, 99) < 30) mem[r * 16 + c] = 8'($urandom_range(1, 255));
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy) begin
        check("first_ram_addr", ram_addr, 8'h00);
        return;
      end
    end
    check("go_accepted", busy, 1);
  endtask

  task automatic wait_fd(input int limit);
    for (int i = 0; i < limit; i++) begin
      tick();
      if (frame_done) return;
    end
    check("frame_done_within_bound", 0, 1);
  endtask

  task automatic run_frame(input int mode, input int fixed_d);
    drv_mode = mode;
    model_frame(mode, fixed_d);
    tick();
    go = 1'b1;
    wait_busy();
    go = 1'b0;
    wait_fd(20000);
    tick();
  endtask

  // Drawer model: pulses done D cycles after start, holds it high, or never answers.
  initial begin
    draw_done = 1'b0;
    forever begin
      tick();
      if (reset) begin
        dcnt = 0;
        draw_done = 1'b0;
      end else if (drv_mode == 1) begin
        draw_done = 1'b1;
      end else if (drv_mode == 2) begin
        draw_done = 1'b0;
      end else begin
        draw_done = 1'b0;
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) draw_done = 1'b1;
        end
        if (draw_start) dcnt = (delayq.size() > 0) ? delayq.pop_front() : 2;
      end
    end
  end

  // Monitor for the main instance.
  initial begin
    int         cyc, start_cyc;
    bit         prev_busy, prev_to, hold_vld, cnt_chk;
    logic [7:0] prev_addr, hold_addr, hold_pos, cnt_exp;
    exp_t       e;
    cyc = 0; start_cyc = 0; prev_busy = 0; prev_to = 0; hold_vld = 0; cnt_chk = 0;
    prev_addr = 8'h00; hold_addr = 8'h00; hold_pos = 8'h00; cnt_exp = 8'h00;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        prev_busy = 0; prev_to = 0; hold_vld = 0; cnt_chk = 0; prev_addr = 8'h00;
      end else begin
        if (busy && !prev_busy) start_cyc = cyc;
        if (cnt_chk) begin
          check("frame_count", frame_count, cnt_exp);
          cnt_chk = 0;
        end
        if (prev_to) check("timeout_sticky", timeout, 1);
        if (ram_addr != prev_addr) begin
          check("ram_addr_legal", (ram_addr[3:0] < 4'd10) && (ram_addr[7:4] < 4'd10), 1);
          hold_vld = 0;
        end
        if (hold_vld) begin
          check("address_held", address, hold_addr);
          check("position_held", position, hold_pos);
          if (draw_done) hold_vld = 0;
        end
        if (draw_start) begin
          if (expq.size() == 0) begin
            check("unexpected_draw_start", address, 32'hffff_ffff);
          end else begin
            e = expq.pop_front();
            check("draw_kind", e.is_frame, 0);
            check("draw_address", address, e.addr);
            check("draw_position", position, e.pos);
          end
          hold_vld = 1; hold_addr = address; hold_pos = position;
        end
        if (frame_done) begin
          if (expq.size() == 0) begin
            check("unexpected_frame_done", 0, 1);
          end else begin
            e = expq.pop_front();
            check("frame_kind", e.is_frame, 1);
            if (e.dur >= 0) check("frame_cycles", cyc - start_cyc, e.dur);
            cnt_chk = 1;
            cnt_exp = e.cnt;
          end
        end
        prev_busy = busy;
        prev_to   = timeout;
        prev_addr = ram_addr;
      end
    end
  end

  // Monitor for the continuous instance: one never-answered tile per frame at (1,2).
  initial begin
    int cyc_b, last, starts;
    bit seen, cnt_pend, prev_to_b;
    cyc_b = 0; last = 0; starts = 0; seen = 0; cnt_pend = 0; prev_to_b = 0;
    forever begin
      @(negedge clock);
      cyc_b++;
      if (!rst_b && !b_done) begin
        if (seen) check("b_busy_held", busy_b, 1);
        if (busy_b) seen = 1;
        if (prev_to_b) check("b_timeout_sticky", timeout_b, 1);
        prev_to_b = timeout_b;
        if (ram_addr_b[3:0] > 4'd2 || ram_addr_b[7:4] > 4'd1) check("b_ram_addr_legal", ram_addr_b, 0);
        if (cnt_pend) begin
          check("b_frame_count", frame_count_b, b_frames % 256);
          cnt_pend = 0;
          if (b_frames == 256) b_done = 1'b1;
        end
        if (draw_start_b) begin
          starts++;
          check("b_address", address_b, 8'h12);
          check("b_position", position_b, 8'h55);
        end
        if (frame_done_b) begin
          if (b_frames > 0) check("b_frame_period", (cyc_b - last >= 40) && (cyc_b - last <= 42), 1);
          check("b_draws_per_frame", starts, 1);
          starts = 0;
          last = cyc_b;
          b_frames++;
          cnt_pend = 1;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rst_b = 1'b1; go = 1'b0;
    clear_board();
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_draw_start", draw_start, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_address", address, 0);
    check("rst_position", position, 0);
    reset = 1'b0; rst_b = 1'b0;

    run_frame(0, 0);
    check("empty_no_timeout", timeout, 0);

    mem[8'h23] = 8'h40;
    run_frame(0, 64);

    for (int k = 0; k < 3; k++) begin
      random_board();
      run_frame(0, 0);
    end

    // go held high across two frames: one IDLE cycle between them.
    random_board();
    drv_mode = 0;
    model_frame(0, 0);
    model_frame(0, 0);
    tick();
    go = 1'b1;
    wait_busy();
    wait_fd(20000);
    tick();
    check("idle_gap_low", busy, 0);
    tick();
    check("idle_gap_restart", busy, 1);
    go = 1'b0;
    wait_fd(20000);
    tick();

    random_board();
    run_frame(1, 0);

    clear_board();
    mem[8'h05] = 8'h11;
    mem[8'h57] = 8'h80;
    check("timeout_before", timeout, 0);
    run_frame(2, 0);
    check("timeout_set", timeout, 1);
    random_board();
    run_frame(0, 0);
    check("timeout_still_set", timeout, 1);

    // Reset while waiting on the drawer at cell (3,4).
    clear_board();
    mem[8'h12] = 8'h07;
    mem[8'h34] = 8'h22;
    drv_mode = 0;
    model_frame(0, 64);
    tick();
    go = 1'b1;
    wait_busy();
    go = 1'b0;
    begin
      bit found;
      found = 0;
      for (int i = 0; i < 3000 && !found; i++) begin
        tick();
        if (draw_start && address == 8'h34) found = 1;
      end
      check("reached_cell_34", found, 1);
    end
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_draw_start", draw_start, 0);
    check("midrst_ram_addr", ram_addr, 0);
    check("midrst_timeout", timeout, 0);
    check("midrst_frame_count", frame_count, 0);
    expq.delete();
    delayq.delete();
    exp_frames = 0;
    dcnt = 0;
    tick();
    reset = 1'b0;
    run_frame(0, 0);

    for (int i = 0; i < 30000 && !b_done; i++) tick();
    check("b_256_frames_done", b_done, 1);
    check("b_timeout_final", timeout_b, 1);
    check("b_frame_count_wrapped", frame_count_b, 0);
    check("scoreboard_empty", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
